rollout_sched: RTL and testbench
================================

ROLLOUT_SCHED -- requirements
Module: rollout_sched

Interface
- REQ-001: Parameter ROLLOUTS, default 4; number of rollouts run per legal direction, range 1..255.
- REQ-002: Parameter TIMEOUT, default 1024; maximum cycles allowed per rollout (used only under REQ-030).
- REQ-003: Parameter SCORE_W, default 36; accumulator width per direction.
- REQ-004: clk  input  1  single clock; all state on rising edge.
- REQ-005: rst  input  1  asynchronous, active-low reset (asserted when 0).
- REQ-006: start  input  1  one-cycle request to begin a search on the current board.
- REQ-007: legal  input  4  bit0=UP, bit1=DOWN, bit2=LEFT, bit3=RIGHT; 1 = move changes the board; sampled with start.
- REQ-008: eng_start  output  1  one-cycle launch pulse to the shared rollout engine.
- REQ-009: eng_dir  output  3  first move of the rollout: UP=1, DOWN=2, LEFT=3, RIGHT=4, 0 = none.
- REQ-010: eng_done  input  1  engine completion strobe; eng_score is valid in the same cycle.
- REQ-011: eng_score  input  31  final tile-sum of the finished rollout.
- REQ-012: busy  output  1  high from the cycle after accepted start through DONE.
- REQ-013: done  output  1  one-cycle pulse when best_dir becomes valid.
- REQ-014: best_dir  output  3  chosen direction code; 0 = no legal move.
- REQ-015: timeout  output  1  sticky flag; a rollout was aborted since the last accepted start.

Function
- REQ-016: FSM states IDLE, ISSUE, WAIT, NEXT, DECIDE, DONE; reset state IDLE.
- REQ-017: IDLE: start=1 latches legal, clears all four accumulators, the rollout counter and timeout, and moves to NEXT; start in any other state is ignored.
- REQ-018: NEXT: select the lowest-coded legal direction not yet finished -> ISSUE; if none remain -> DECIDE.
- REQ-019: ISSUE: eng_start=1 for exactly one cycle with eng_dir = selected code -> WAIT.
- REQ-020: WAIT: on eng_done, add eng_score (zero-extended) to that direction's accumulator, saturating at 2^SCORE_W-1; increment the rollout counter; counter==ROLLOUTS -> clear counter, mark direction finished, go to NEXT; otherwise -> ISSUE.
- REQ-021: eng_done outside WAIT is ignored; eng_dir holds its value throughout WAIT.
- REQ-022: DECIDE (one cycle): best_dir = legal direction with largest accumulator; ties go to UP > DOWN > LEFT > RIGHT; no legal bits -> best_dir=0 -> DONE.
- REQ-023: DONE: done=1 for one cycle -> IDLE; best_dir holds until the next DECIDE.
- REQ-024: legal=0000 at start yields done exactly 3 cycles after start (NEXT, DECIDE, DONE) with best_dir=0 and no eng_start.
- REQ-025: Minimum latency per rollout: 2 cycles (ISSUE + one WAIT cycle when eng_done arrives the cycle after eng_start).

Reset
- REQ-026: rst=0 forces IDLE, eng_start=0, eng_dir=0, busy=0, done=0, best_dir=0, timeout=0, all accumulators and counters 0, without waiting for clk.
- REQ-027: Reset mid-search abandons the search; no done pulse follows release; engine results arriving after release are ignored.
- REQ-028: Outputs are registered; no combinational path from eng_done or start to any output.

Configuration
- REQ-029: Macro ROLLOUT_SCHED_TIMEOUT_EN selects the watchdog.
- REQ-030: Defined: a cycle counter loads at ISSUE; if TIMEOUT cycles elapse in WAIT without eng_done, the rollout counts as finished with score 0, timeout sets, and the FSM advances as in REQ-020.
- REQ-031: Undefined: no watchdog logic; WAIT waits indefinitely; timeout tied to 0.

Structure
- REQ-032: Shared package ai_pkg holds direction codes (UP..RIGHT, NONE), the FSM state type, and SCORE_W default.
- REQ-033: Sub-module score_argmax: combinational 4-way compare of accumulators with legal mask and tie priority, returning a direction code.

Verification
- REQ-034: legal=1111, ROLLOUTS=2, engine returns 100 for all -> 8 eng_start pulses in order UP,UP,DOWN,DOWN,LEFT,LEFT,RIGHT,RIGHT; best_dir=1 (tie).
- REQ-035: legal=0110, scores DOWN 50+60, LEFT 70+41 -> no UP/RIGHT issues; best_dir=3.
- REQ-036: legal=0000 -> done 3 cycles after start, best_dir=0, eng_start never high.
- REQ-037: rst pulled low during third WAIT -> all outputs 0 immediately; late eng_done ignored; next start runs cleanly.
- REQ-038: With ROLLOUT_SCHED_TIMEOUT_EN, TIMEOUT=16, engine silent for UP -> after 16 WAIT cycles, timeout=1 and search proceeds; without macro, FSM remains in WAIT.
- REQ-039: start pulsed while busy -> ignored; saturation check: eng_score=2^31-1 repeated with SCORE_W=32 -> accumulator clamps at 2^32-1.

Source files
------------

// File: rtl/ai_pkg.sv
// rtl/ai_pkg.sv - shared direction codes, FSM state type and defaults for rollout_sched
package ai_pkg;

    localparam int SCORE_W_DEF = 36;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DECIDE,
        S_DONE
    } state_e;

    // Legal-mask bit index (0=UP..3=RIGHT) to engine direction code.
    function automatic logic [2:0] dir_of_idx(input logic [1:0] idx);
        return {1'b0, idx} + 3'd1;
    endfunction

endpackage

// File: rtl/rollout_sched_if.sv
// rtl/rollout_sched_if.sv - launch/completion handshake between scheduler and rollout engine
interface rollout_sched_if;

    logic        eng_start;
    logic [2:0]  eng_dir;
    logic        eng_done;
    logic [30:0] eng_score;

    modport master (
        output eng_start,
        output eng_dir,
        input  eng_done,
        input  eng_score
    );

    modport slave (
        input  eng_start,
        input  eng_dir,
        output eng_done,
        output eng_score
    );

endinterface

// File: rtl/score_argmax.sv
// rtl/score_argmax.sv - picks the legal direction with the largest accumulated score
module score_argmax
    import ai_pkg::*;
#(
    parameter int W = SCORE_W_DEF
) (
    input  logic [3:0][W-1:0] acc,
    input  logic [3:0]        legal,
    output logic [2:0]        dir
);

    logic [W-1:0] best_val;

    // Scan UP..RIGHT; strict '>' lets the earlier direction keep a tie.
    always_comb begin
        best_val = '0;
        dir      = DIR_NONE;
        for (int i = 0; i < 4; i++) begin
            if (legal[i] && ((dir == DIR_NONE) || (acc[i] > best_val))) begin
                best_val = acc[i];
                dir      = dir_of_idx(2'(i));
            end
        end
    end

endmodule

// File: rtl/rollout_sched.sv
// rtl/rollout_sched.sv - rollout scheduler: runs ROLLOUTS engine rollouts per legal move, picks best (watchdog: ROLLOUT_SCHED_TIMEOUT_EN)
module rollout_sched
    import ai_pkg::*;
#(
    parameter int ROLLOUTS = 4,
    parameter int TIMEOUT  = 1024,
    parameter int SCORE_W  = SCORE_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [3:0]             legal,
    rollout_sched_if.master        eng,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             best_dir,
    output logic                   timeout
);

    if (ROLLOUTS < 1 || ROLLOUTS > 255 || TIMEOUT < 1 || SCORE_W < 31) begin : g_bad_cfg
        $error("rollout_sched: unsupported parameter set");
    end

    state_e                   state;
    logic [3:0]               legal_q;
    logic [3:0]               fin;
    logic [1:0]               cur;
    logic [7:0]               cnt;
    logic [3:0][SCORE_W-1:0]  acc;

    logic [3:0]               pending;
    logic [1:0]               next_idx;
    logic                     any_pending;
    logic [2:0]               argmax_dir;
    logic                     rollout_end;
    logic                     last_rollout;
    logic [30:0]              add_score;
    logic [SCORE_W:0]         sum;
    logic [SCORE_W-1:0]       sum_sat;

    assign pending     = legal_q & ~fin;
    assign any_pending = |pending;

    // Lowest-coded direction that still has rollouts to run.
    always_comb begin
        next_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending[i]) begin
                next_idx = 2'(i);
            end
        end
    end

`ifdef ROLLOUT_SCHED_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT + 1);

    logic [WDOG_W-1:0] wdog;
    logic              wdog_hit;

    assign wdog_hit    = (state == S_WAIT) && !eng.eng_done && (wdog == WDOG_W'(TIMEOUT - 1));
    assign rollout_end = ((state == S_WAIT) && eng.eng_done) || wdog_hit;
    assign add_score   = eng.eng_done ? eng.eng_score : 31'd0;

    // Counts WAIT cycles of the current rollout; restarts on every launch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog <= '0;
        end else if (state == S_ISSUE) begin
            wdog <= '0;
        end else if (state == S_WAIT) begin
            wdog <= wdog + 1'b1;
        end
    end
`else
    assign rollout_end = (state == S_WAIT) && eng.eng_done;
    assign add_score   = eng.eng_score;
`endif

    assign last_rollout = (cnt == 8'(ROLLOUTS - 1));

    // Accumulate with clamp at all-ones instead of wrapping.
    assign sum     = {1'b0, acc[cur]} + (SCORE_W+1)'(add_score);
    assign sum_sat = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];

    score_argmax #(
        .W (SCORE_W)
    ) u_argmax (
        .acc   (acc),
        .legal (legal_q),
        .dir   (argmax_dir)
    );

    // Search sequencer; every output is a register updated here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            legal_q       <= '0;
            fin           <= '0;
            cur           <= '0;
            cnt           <= '0;
            acc           <= '0;
            eng.eng_start <= 1'b0;
            eng.eng_dir   <= DIR_NONE;
            busy          <= 1'b0;
            done          <= 1'b0;
            best_dir      <= DIR_NONE;
            timeout       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        legal_q <= legal;
                        fin     <= '0;
                        acc     <= '0;
                        cnt     <= '0;
                        timeout <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (any_pending) begin
                        cur           <= next_idx;
                        eng.eng_dir   <= dir_of_idx(next_idx);
                        eng.eng_start <= 1'b1;
                        state         <= S_ISSUE;
                    end else begin
                        eng.eng_dir   <= DIR_NONE;
                        state         <= S_DECIDE;
                    end
                end
                S_ISSUE: begin
                    eng.eng_start <= 1'b0;
                    state         <= S_WAIT;
                end
                S_WAIT: begin
                    if (rollout_end) begin
                        acc[cur] <= sum_sat;
`ifdef ROLLOUT_SCHED_TIMEOUT_EN
                        if (wdog_hit) begin
                            timeout <= 1'b1;
                        end
`endif
                        if (last_rollout) begin
                            cnt      <= '0;
                            fin[cur] <= 1'b1;
                            state    <= S_NEXT;
                        end else begin
                            cnt           <= cnt + 8'd1;
                            eng.eng_start <= 1'b1;
                            state         <= S_ISSUE;
                        end
                    end
                end
                S_DECIDE: begin
                    best_dir <= argmax_dir;
                    done     <= 1'b1;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rollout_sched.sv
// tb/tb_rollout_sched.sv - scoreboard bench for rollout_sched with a behavioural rollout engine
module tb_rollout_sched;
    import ai_pkg::*;

    localparam int ROLL = 3;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic [3:0] legal = 4'b0;
    logic       busy;
    logic       done;
    logic [2:0] best_dir;
    logic       timeout;

    rollout_sched_if eng_if ();

    rollout_sched #(
        .ROLLOUTS (ROLL),
        .TIMEOUT  (16),
        .SCORE_W  (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .legal    (legal),
        .eng      (eng_if),
        .busy     (busy),
        .done     (done),
        .best_dir (best_dir),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    int          vectors    = 0;
    int          miscompares = 0;
    int          n_issue    = 0;
    bit          engine_on  = 1'b1;
    int          eng_lat    = 1;
    logic [2:0]  exp_dir_q[$];
    logic [2:0]  exp_best_q[$];
    logic [30:0] score_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_dirs(input logic [2:0] d);
        for (int i = 0; i < ROLL; i++) exp_dir_q.push_back(d);
    endtask

    task automatic pulse_start(input logic [3:0] l);
        @(negedge clk);
        legal = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no done within 500 cycles", name);
        end
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      32'(busy),             32'd0);
        chk({tag, "_done"},      32'(done),             32'd0);
        chk({tag, "_best_dir"},  32'(best_dir),         32'd0);
        chk({tag, "_timeout"},   32'(timeout),          32'd0);
        chk({tag, "_eng_start"}, 32'(eng_if.eng_start), 32'd0);
        chk({tag, "_eng_dir"},   32'(eng_if.eng_dir),   32'd0);
    endtask

    // Behavioural engine: answers each launch eng_lat cycles later.
    initial begin
        int cd = 0;
        eng_if.eng_done  = 1'b0;
        eng_if.eng_score = '0;
        forever begin
            @(negedge clk);
            eng_if.eng_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    eng_if.eng_done  = 1'b1;
                    eng_if.eng_score = (score_q.size() > 0) ? score_q.pop_front() : 31'd0;
                end
            end
            if (eng_if.eng_start && engine_on) cd = eng_lat;
        end
    end

    // Monitor: every launch and every done pulse is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (eng_if.eng_start) begin
                n_issue++;
                if (exp_dir_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_eng_start: dir %0d issued, none expected", eng_if.eng_dir);
                end else begin
                    chk("eng_dir", 32'(eng_if.eng_dir), 32'(exp_dir_q.pop_front()));
                end
            end
            if (done) begin
                if (exp_best_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: best_dir %0d, none expected", best_dir);
                end else begin
                    chk("best_dir", 32'(best_dir), 32'(exp_best_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int base;
        int n;

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;

        // All four legal, equal scores: tie resolves to UP.
        push_dirs(3'd1); push_dirs(3'd2); push_dirs(3'd3); push_dirs(3'd4);
        for (int i = 0; i < 4 * ROLL; i++) score_q.push_back(31'd100);
        exp_best_q.push_back(3'd1);
        pulse_start(4'b1111);
        wait_done("all_legal_tie");
        chk("all_legal_issues_left", 32'(exp_dir_q.size()), 32'd0);
        chk("all_legal_busy_after", 32'(busy), 32'd0);
        chk("all_legal_timeout", 32'(timeout), 32'd0);

        // DOWN 120 vs LEFT 131; a start while busy must be ignored.
        push_dirs(3'd2); push_dirs(3'd3);
        score_q.push_back(31'd50); score_q.push_back(31'd60); score_q.push_back(31'd10);
        score_q.push_back(31'd70); score_q.push_back(31'd41); score_q.push_back(31'd20);
        exp_best_q.push_back(3'd3);
        pulse_start(4'b0110);
        repeat (3) @(negedge clk);
        legal = 4'b1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_during_search", 32'(busy), 32'd1);
        wait_done("down_left");
        chk("down_left_issues_left", 32'(exp_dir_q.size()), 32'd0);

        // No legal move: done exactly three cycles after start.
        exp_best_q.push_back(3'd0);
        @(negedge clk);
        legal = 4'b0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("none_busy_c1", 32'(busy), 32'd1);
        chk("none_done_c1", 32'(done), 32'd0);
        @(negedge clk);
        chk("none_done_c2", 32'(done), 32'd0);
        @(negedge clk);
        chk("none_done_c3", 32'(done), 32'd1);
        chk("none_best_dir", 32'(best_dir), 32'd0);
        @(negedge clk);

        // UP 6 vs RIGHT 7.
        push_dirs(3'd1); push_dirs(3'd4);
        score_q.push_back(31'd1); score_q.push_back(31'd2); score_q.push_back(31'd3);
        score_q.push_back(31'd3); score_q.push_back(31'd2); score_q.push_back(31'd2);
        exp_best_q.push_back(3'd4);
        pulse_start(4'b1001);
        wait_done("up_right");

        // LEFT 10 ties RIGHT 10: LEFT wins.
        push_dirs(3'd3); push_dirs(3'd4);
        score_q.push_back(31'd10); score_q.push_back(31'd0); score_q.push_back(31'd0);
        score_q.push_back(31'd5);  score_q.push_back(31'd5); score_q.push_back(31'd0);
        exp_best_q.push_back(3'd3);
        pulse_start(4'b1100);
        wait_done("left_right_tie");

        // Saturation: UP clamps at 2^32-1, beating DOWN at 2^32-2; slower engine.
        eng_lat = 3;
        push_dirs(3'd1); push_dirs(3'd2);
        for (int i = 0; i < 3; i++) score_q.push_back(31'h7FFF_FFFF);
        score_q.push_back(31'h7FFF_FFFF); score_q.push_back(31'h7FFF_FFFF); score_q.push_back(31'd0);
        exp_best_q.push_back(3'd1);
        pulse_start(4'b0011);
        wait_done("saturation");

        // Reset during the third WAIT; the late engine result must be ignored.
        eng_lat = 2;
        push_dirs(3'd1);
        for (int i = 0; i < 4; i++) score_q.push_back(31'd100);
        base = n_issue;
        pulse_start(4'b1111);
        n = 0;
        while (n_issue < base + 3 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reset_reached_third_issue", 32'(n_issue - base), 32'd3);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all_zero("midreset");
        exp_dir_q.delete();
        exp_best_q.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_best_dir", 32'(best_dir), 32'd0);
        score_q.delete();
        eng_lat = 1;

        // Clean run after reset.
        push_dirs(3'd3);
        score_q.push_back(31'd1); score_q.push_back(31'd2); score_q.push_back(31'd3);
        exp_best_q.push_back(3'd3);
        pulse_start(4'b0100);
        wait_done("after_reset");

        // Silent engine on UP.
        engine_on = 1'b0;
`ifdef ROLLOUT_SCHED_TIMEOUT_EN
        push_dirs(3'd1);
        exp_best_q.push_back(3'd1);
        pulse_start(4'b0001);
        wait_done("watchdog");
        chk("watchdog_timeout", 32'(timeout), 32'd1);
`else
        exp_dir_q.push_back(3'd1);
        pulse_start(4'b0001);
        repeat (40) @(negedge clk);
        chk("silent_busy", 32'(busy), 32'd1);
        chk("silent_eng_dir", 32'(eng_if.eng_dir), 32'd1);
        chk("silent_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
`endif
        engine_on = 1'b1;
        repeat (3) @(negedge clk);
        chk("final_dir_queue_empty", 32'(exp_dir_q.size()), 32'd0);
        chk("final_best_queue_empty", 32'(exp_best_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
